if_prefetch_queue: RTL and testbench

- Parametrised successor to the single-word fetch stage.
- Holds the PC register, a synchronous instruction memory with a debug load port, and a FIFO_DEPTH-entry prefetch queue of {pc, instruction} pairs.
- The queue feeds ID through a valid/ready handshake.
- Supports EX/branch redirect with queue flush and self-halt on a HALT opcode. Sits between the debug unit / branch logic and the IF/ID boundary.

---
 rtl/if_prefetch_queue.sv | 127 ++++++++++++
 tb/tb_if_prefetch_queue.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_queue.sv
// Instruction fetch stage: PC, synchronous instruction memory with debug load,
// and a small prefetch queue of {pc, instruction} pairs handed to ID.
module if_prefetch_queue #(
    parameter int                        SIZE_PC      = 32,
    parameter int                        SIZE_REG_MEM = 32,
    parameter int                        MEM_DEPTH    = 256,
    parameter int                        FIFO_DEPTH   = 4,
    parameter logic [SIZE_PC-1:0]        RESET_PC     = '0,
    parameter logic [SIZE_REG_MEM-1:0]   HALT_OPCODE  = '1
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_enable,
    input  logic                          i_redirect,
    input  logic [SIZE_PC-1:0]            i_redirect_pc,
    input  logic                          i_load_en,
    input  logic [SIZE_REG_MEM-1:0]       i_load_data,
    input  logic                          i_instr_ready,
    output logic                          o_instr_valid,
    output logic [SIZE_REG_MEM-1:0]       o_instruction,
    output logic [SIZE_PC-1:0]            o_pc,
    output logic [SIZE_PC-1:0]            o_pc4,
    output logic                          o_halted,
    output logic [$clog2(FIFO_DEPTH):0]   o_count
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam int QW = $clog2(FIFO_DEPTH);
    localparam int CW = QW + 1;

    typedef struct packed {
        logic [SIZE_PC-1:0]      pc;
        logic [SIZE_REG_MEM-1:0] instr;
    } entry_t;

    logic [SIZE_REG_MEM-1:0] mem [MEM_DEPTH];
    entry_t                  queue [FIFO_DEPTH];

    logic [SIZE_PC-1:0]      fetch_pc;
    logic [SIZE_PC-1:0]      issue_pc;
    logic [SIZE_REG_MEM-1:0] mem_rdata;
    logic                    inflight;
    logic                    halted;
    logic [QW-1:0]           head;
    logic [QW-1:0]           tail;
    logic [CW-1:0]           count;
    logic [AW-1:0]           load_ptr;

    logic                    issue;
    logic                    push;
    logic                    pop;
    logic                    load_we;
    logic                    halt_seen;
    logic                    has_room;
    logic [CW:0]             credit;

    // A slot freed by this cycle's pop may be reused by this cycle's issue,
    // which keeps one fetch per cycle even with a two-entry queue.
    always_comb begin
        pop       = (count != '0) && i_instr_ready;
        push      = inflight && !i_redirect;
        halt_seen = inflight && (mem_rdata == HALT_OPCODE);
        credit    = (CW+1)'(count) + (CW+1)'(inflight) - (CW+1)'(pop);
        has_room  = credit < (CW+1)'(FIFO_DEPTH);
        issue     = i_enable && !halted && !halt_seen && has_room && !i_redirect;
        load_we   = !i_enable && i_load_en;
    end

    always_ff @(posedge i_clk) begin
        if (load_we)
            mem[load_ptr] <= i_load_data;
        if (issue)
            mem_rdata <= mem[fetch_pc[AW+1:2]];
    end

    always_ff @(posedge i_clk) begin
        if (push)
            queue[tail] <= '{pc: issue_pc, instr: mem_rdata};
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            fetch_pc <= RESET_PC;
            issue_pc <= '0;
            inflight <= 1'b0;
            halted   <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            load_ptr <= '0;
        end else begin
            if (load_we)
                load_ptr <= load_ptr + AW'(1);
            if (i_redirect) begin
                fetch_pc <= i_redirect_pc;
                inflight <= 1'b0;
                halted   <= 1'b0;
                head     <= '0;
                tail     <= '0;
                count    <= '0;
            end else begin
                inflight <= issue;
                if (issue) begin
                    issue_pc <= fetch_pc;
                    fetch_pc <= fetch_pc + SIZE_PC'(4);
                end
                if (push)
                    tail <= tail + QW'(1);
                if (pop)
                    head <= head + QW'(1);
                count <= count + CW'(push) - CW'(pop);
                if (halt_seen)
                    halted <= 1'b1;
            end
        end
    end

    always_comb begin
        o_instr_valid = (count != '0);
        o_instruction = o_instr_valid ? queue[head].instr : '0;
        o_pc          = o_instr_valid ? queue[head].pc : '0;
        o_pc4         = o_instr_valid ? queue[head].pc + SIZE_PC'(4) : '0;
        o_halted      = halted;
        o_count       = count;
    end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue: default-depth instance plus a
// two-entry instance driven from the same stimulus.
module tb_if_prefetch_queue;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        load_en;
    logic [31:0] load_data;
    logic        ready;

    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        halted;
    logic [2:0]  count;

    logic        valid2;
    logic [31:0] instr2;
    logic [31:0] pc2;
    logic [31:0] pc42;
    logic        halted2;
    logic [1:0]  count2;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] prog1 [4];
    logic [31:0] prog2 [6];

    if_prefetch_queue dut (
        .i_clk         (clk),
        .i_reset       (rst_n),
        .i_enable      (enable),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .i_load_en     (load_en),
        .i_load_data   (load_data),
        .i_instr_ready (ready),
        .o_instr_valid (valid),
        .o_instruction (instr),
        .o_pc          (pc),
        .o_pc4         (pc4),
        .o_halted      (halted),
        .o_count       (count)
    );

    if_prefetch_queue #(.FIFO_DEPTH(2)) dut_d2 (
        .i_clk         (clk),
        .i_reset       (rst_n),
        .i_enable      (enable),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .i_load_en     (load_en),
        .i_load_data   (load_data),
        .i_instr_ready (ready),
        .o_instr_valid (valid2),
        .o_instruction (instr2),
        .o_pc          (pc2),
        .o_pc4         (pc42),
        .o_halted      (halted2),
        .o_count       (count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load_word(input logic [31:0] w);
        load_en   = 1'b1;
        load_data = w;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        enable   = 1'b0;
        ready    = 1'b0;
        redirect = 1'b0;
        load_en  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        prog1[0] = 32'h20010005;
        prog1[1] = 32'h20020007;
        prog1[2] = 32'h00221820;
        prog1[3] = 32'hFFFFFFFF;
        prog2[0] = 32'h00000013;
        prog2[1] = 32'h00100093;
        prog2[2] = 32'h00200113;
        prog2[3] = 32'h00300193;
        prog2[4] = 32'h00400213;
        prog2[5] = 32'h00500293;

        rst_n       = 1'b1;
        enable      = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        load_en     = 1'b0;
        load_data   = '0;
        ready       = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", valid, 0);
        check("rst_instr", instr, 0);
        check("rst_pc", pc, 0);
        check("rst_pc4", pc4, 0);
        check("rst_halted", halted, 0);
        check("rst_count", count, 0);

        // Program ending in HALT, run with ID always ready
        do_reset();
        for (int i = 0; i < 4; i++)
            load_word(prog1[i]);
        enable = 1'b1;
        ready  = 1'b1;
        tick();
        check("t1_lat_valid", valid, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t1_valid", valid, 1);
            check("t1_pc", pc, 4 * k);
            check("t1_pc4", pc4, 4 * k + 4);
            check("t1_instr", instr, prog1[k]);
            check("t1_halted", halted, (k == 3) ? 1 : 0);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t1_post_valid", valid, 0);
            check("t1_post_halted", halted, 1);
        end
        redirect    = 1'b1;
        redirect_pc = 32'h0;
        tick();
        redirect = 1'b0;
        check("t1_redir_halted", halted, 0);
        check("t1_redir_valid", valid, 0);
        tick();
        check("t1_redir_lat", valid, 0);
        tick();
        check("t1_redir_v", valid, 1);
        check("t1_redir_pc", pc, 0);
        check("t1_redir_instr", instr, prog1[0]);

        // Back-pressure saturation, ignored load strobe while running
        do_reset();
        for (int i = 0; i < 5; i++)
            load_word(prog2[i]);
        enable    = 1'b1;
        ready     = 1'b0;
        load_en   = 1'b1;
        load_data = 32'hDEADBEEF;
        for (int i = 0; i < 6; i++)
            tick();
        check("t2_sat_count", count, 4);
        check("t2_sat_pc", pc, 0);
        check("t2_sat_instr", instr, prog2[0]);
        tick();
        check("t2_sat_hold", count, 4);
        ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            tick();
            check("t2_drain_pc", pc, 4 * k);
            check("t2_drain_instr", instr, prog2[k]);
        end
        enable    = 1'b0;
        load_data = prog2[5];
        tick();
        load_en     = 1'b0;
        enable      = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'd20;
        tick();
        redirect = 1'b0;
        check("t2_redir_count", count, 0);
        tick();
        tick();
        check("t2_ptr_valid", valid, 1);
        check("t2_ptr_pc", pc, 20);
        check("t2_ptr_instr", instr, prog2[5]);

        // Redirect with three queued entries and one in flight
        do_reset();
        enable = 1'b1;
        ready  = 1'b0;
        for (int i = 0; i < 4; i++)
            tick();
        check("t3_pre_count", count, 3);
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        check("t3_flush_count", count, 0);
        check("t3_flush_valid", valid, 0);
        tick();
        check("t3_lat_valid", valid, 0);
        tick();
        check("t3_tgt_valid", valid, 1);
        check("t3_tgt_pc", pc, 32'h40);
        check("t3_tgt_pc4", pc4, 32'h44);
        ready = 1'b1;
        tick();
        check("t3_next_pc", pc, 32'h44);

        // Two-entry queue: full throughput across pointer wrap
        do_reset();
        enable = 1'b1;
        ready  = 1'b1;
        tick();
        check("t5_lat_valid", valid2, 0);
        for (int k = 0; k < 8; k++) begin
            tick();
            check("t5_count", count2, 1);
            check("t5_pc", pc2, 4 * k);
            if (k < 6)
                check("t5_instr", instr2, prog2[k]);
        end

        // Asynchronous reset mid-stream
        do_reset();
        enable = 1'b1;
        ready  = 1'b0;
        for (int i = 0; i < 4; i++)
            tick();
        check("t6_pre_count", count, 3);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_valid", valid, 0);
        check("t6_async_count", count, 0);
        check("t6_async_pc", pc, 0);
        check("t6_async_pc4", pc4, 0);
        check("t6_async_instr", instr, 0);
        check("t6_async_halted", halted, 0);
        tick();
        rst_n = 1'b1;
        ready = 1'b1;
        tick();
        check("t6_lat_valid", valid, 0);
        tick();
        check("t6_valid", valid, 1);
        check("t6_pc", pc, 0);
        check("t6_instr", instr, prog2[0]);
        tick();
        check("t6_pc_next", pc, 4);
        check("t6_instr_next", instr, prog2[1]);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
